clock_divider_bank: RTL and testbench

- Multi-channel programmable clock-divider bank; successor to the fixed cascade of divide-by-2 stages that drives the imem/dmem/processor/regfile clocks.
- Produces NUM_CH divided clocks plus one-cycle tick pulses from a single master clock.
- Each channel has a runtime-programmable integer ratio.
- Ratio changes are applied glitch-free at period boundaries, and a global align restarts all channels phase-coherently.

---
 rtl/clkdiv_pkg.sv | 21 ++
 rtl/clock_divider_bank_if.sv | 14 +
 rtl/clkdiv_channel.sv | 107 ++++++++++
 rtl/clock_divider_bank.sv | 63 ++++++
 tb/tb_clock_divider_bank.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared constants, per-channel config record and helpers for the divider bank
package clkdiv_pkg;
    localparam int MIN_DIV   = 2;
    localparam int DEF_CNT_W = 8;

    // Field widths follow DEF_CNT_W, so channel CNT_W is expected to match it.
    typedef struct packed {
        logic [DEF_CNT_W-1:0] div;
        logic [DEF_CNT_W-1:0] half;
        logic [DEF_CNT_W-1:0] pending_div;
        logic                 pending;
    } ch_cfg_t;

    function automatic logic [DEF_CNT_W-1:0] half_of(input logic [DEF_CNT_W-1:0] d);
        return d >> 1;
    endfunction

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/clock_divider_bank_if.sv
// rtl/clock_divider_bank_if.sv - configuration write channel with one-cycle ack/err response
interface clock_divider_bank_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = clkdiv_pkg::DEF_CNT_W
);
    logic                                cfg_we;
    logic [clkdiv_pkg::ch_w(NUM_CH)-1:0] cfg_ch;
    logic [CNT_W-1:0]                    cfg_div;
    logic                                cfg_ack;
    logic                                cfg_err;

    modport master (output cfg_we, cfg_ch, cfg_div, input  cfg_ack, cfg_err);
    modport slave  (input  cfg_we, cfg_ch, cfg_div, output cfg_ack, cfg_err);
endinterface

// File: rtl/clkdiv_channel.sv
// rtl/clkdiv_channel.sv - one divider channel: counter, period-boundary apply, div_clk/tick registers
// With CLKDIV_GATE_EN an en_i input holds the channel idle and restarts it like a reset release.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             align_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wr_div_i,
`ifdef CLKDIV_GATE_EN
    input  logic             en_i,
`endif
    output logic             pending_o,
    output logic             div_clk_o,
    output logic             tick_o
);
    ch_cfg_t          cfg_q, cfg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
    logic             div_clk_q, div_clk_d, tick_q, tick_d;
    logic             run, resume, wrap;

`ifdef CLKDIV_GATE_EN
    logic dis_q;
    assign run    = en_i;
    assign resume = dis_q;
`else
    assign run    = 1'b1;
    assign resume = 1'b0;
`endif

    assign wrap    = (cnt_q == cfg_q.div - CNT_W'(1));
    assign cnt_nxt = wrap ? '0 : cnt_q + CNT_W'(1);

    always_comb begin
        cfg_d     = cfg_q;
        cnt_d     = cnt_q;
        div_clk_d = div_clk_q;
        tick_d    = tick_q;
        if (!run) begin
            cnt_d     = '0;
            div_clk_d = 1'b0;
            tick_d    = 1'b0;
        end else begin
            if (cfg_q.pending && (align_i || resume || wrap)) begin
                cfg_d.div     = cfg_q.pending_div;
                cfg_d.half    = half_of(cfg_q.pending_div);
                cfg_d.pending = 1'b0;
            end
            if (align_i) begin
                cnt_d     = '0;
                div_clk_d = 1'b1;
                tick_d    = 1'b1;
            end else if (resume) begin
                // Idle edge stood in for cnt=0, so the first running edge lands on cnt=1.
                cnt_d     = CNT_W'(1);
                div_clk_d = (CNT_W'(1) < cfg_d.half);
                tick_d    = 1'b0;
            end else begin
                cnt_d     = cnt_nxt;
                div_clk_d = (cnt_nxt < cfg_d.half);
                tick_d    = (cnt_nxt == '0);
            end
        end
        if (wr_i) begin
            if (run && align_i) begin
                cfg_d.div     = wr_div_i;
                cfg_d.half    = half_of(wr_div_i);
                cfg_d.pending = 1'b0;
            end else begin
                cfg_d.pending_div = wr_div_i;
                cfg_d.pending     = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cfg_q     <= '{div:         CNT_W'(DEFAULT_DIV),
                           half:        CNT_W'(DEFAULT_DIV / 2),
                           pending_div: CNT_W'(DEFAULT_DIV),
                           pending:     1'b0};
            cnt_q     <= '0;
            div_clk_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cfg_q     <= cfg_d;
            cnt_q     <= cnt_d;
            div_clk_q <= div_clk_d;
            tick_q    <= tick_d;
        end
    end

`ifdef CLKDIV_GATE_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) dis_q <= 1'b0;
        else        dis_q <= ~en_i;
    end
`endif

    assign pending_o = cfg_q.pending;
    assign div_clk_o = div_clk_q;
    assign tick_o    = tick_q;
endmodule

// File: rtl/clock_divider_bank.sv
// rtl/clock_divider_bank.sv - NUM_CH programmable clock dividers with glitch-free ratio updates
// Optional macro CLKDIV_GATE_EN adds per-channel enable input ch_en.
module clock_divider_bank
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    clock_divider_bank_if.slave  cfg,
    input  logic                 align,
`ifdef CLKDIV_GATE_EN
    input  logic [NUM_CH-1:0]    ch_en,
`endif
    output logic [NUM_CH-1:0]    pending,
    output logic [NUM_CH-1:0]    div_clk,
    output logic [NUM_CH-1:0]    tick
);
    localparam int CH_W = ch_w(NUM_CH);

    logic [31:0] ch_idx;
    logic        cfg_ok, ack_q, ack_d, err_q, err_d;

    // Widen before the range check so non-power-of-two banks reject the unused codes.
    assign ch_idx = 32'(cfg.cfg_ch);
    assign cfg_ok = (ch_idx < NUM_CH) && (cfg.cfg_div >= CNT_W'(MIN_DIV));
    assign ack_d  = cfg.cfg_we & cfg_ok;
    assign err_d  = cfg.cfg_we & ~cfg_ok;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
            err_q <= err_d;
        end
    end

    assign cfg.cfg_ack = ack_q;
    assign cfg.cfg_err = err_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clkdiv_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clock     (clock),
            .reset     (reset),
            .align_i   (align),
            .wr_i      (ack_d && (cfg.cfg_ch == CH_W'(i))),
            .wr_div_i  (cfg.cfg_div),
`ifdef CLKDIV_GATE_EN
            .en_i      (ch_en[i]),
`endif
            .pending_o (pending[i]),
            .div_clk_o (div_clk[i]),
            .tick_o    (tick[i])
        );
    end
endmodule

// File: tb/tb_clock_divider_bank.sv
// tb/tb_clock_divider_bank.sv - scoreboard bench for clock_divider_bank
module tb_clock_divider_bank;
    localparam int N = 4;

    logic         clock  = 1'b0;
    logic         reset  = 1'b0;
    logic         align  = 1'b0;
    logic         align3 = 1'b0;
    logic [N-1:0] pending, div_clk, tick;
    logic [2:0]   pending3, div_clk3, tick3;
`ifdef CLKDIV_GATE_EN
    logic [N-1:0] ch_en  = '1;
    logic [2:0]   ch_en3 = '1;
`endif

    clock_divider_bank_if #(.NUM_CH(N), .CNT_W(8)) cfg ();
    clock_divider_bank_if #(.NUM_CH(3), .CNT_W(8)) cfg3 ();

    clock_divider_bank #(.NUM_CH(N), .CNT_W(8), .DEFAULT_DIV(2)) dut (
        .clock   (clock),
        .reset   (reset),
        .cfg     (cfg),
        .align   (align),
`ifdef CLKDIV_GATE_EN
        .ch_en   (ch_en),
`endif
        .pending (pending),
        .div_clk (div_clk),
        .tick    (tick)
    );

    clock_divider_bank #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(2)) dut3 (
        .clock   (clock),
        .reset   (reset),
        .cfg     (cfg3),
        .align   (align3),
`ifdef CLKDIV_GATE_EN
        .ch_en   (ch_en3),
`endif
        .pending (pending3),
        .div_clk (div_clk3),
        .tick    (tick3)
    );

    typedef struct {
        int           cyc;
        logic [N-1:0] tk;
        logic [N-1:0] dc;
        logic [N-1:0] pd;
    } exp_t;

    typedef struct {
        int         cyc;
        logic [1:0] ae;
    } rsp_t;

    exp_t         exp_q[$];
    rsp_t         rsp_q[$];
    exp_t         me;
    rsp_t         mr;
    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    int           cyc_s   = 0;
    int           anc[N];
    int           rat[N];
    logic [N-1:0] pexp;
    logic [N-1:0] dis;

    always #5 clock = ~clock;

    always @(posedge clock or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Expected outputs for edge k: a channel with ratio r restarted at edge a sits at phase (k-a)%r.
    function automatic exp_t mk(input int k);
        exp_t e;
        int   m;
        e.cyc = k;
        e.tk  = '0;
        e.dc  = '0;
        e.pd  = pexp;
        for (int i = 0; i < N; i++) begin
            if (!dis[i]) begin
                m       = (k - anc[i]) % rat[i];
                e.tk[i] = (m == 0);
                e.dc[i] = (m < rat[i] / 2);
            end
        end
        return e;
    endfunction

    task automatic step();
        exp_q.push_back(mk(cyc_s + 1));
        @(posedge clock);
        #1;
        cyc_s++;
        cfg.cfg_we = 1'b0;
        align      = 1'b0;
    endtask

    task automatic wr(input int ch, input int dv, input bit ok);
        rsp_t r;
        cfg.cfg_we  = 1'b1;
        cfg.cfg_ch  = 2'(ch);
        cfg.cfg_div = 8'(dv);
        r.cyc = cyc_s + 1;
        r.ae  = ok ? 2'b10 : 2'b01;
        rsp_q.push_back(r);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            anc[i] = 0;
            rat[i] = 2;
        end
        pexp  = '0;
        dis   = '0;
        cyc_s = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_div_clk"}, 32'(div_clk), 32'd0);
        chk({tag, "_tick"},    32'(tick),    32'd0);
        chk({tag, "_pending"}, 32'(pending), 32'd0);
        chk({tag, "_ack"},     32'(cfg.cfg_ack), 32'd0);
        chk({tag, "_err"},     32'(cfg.cfg_err), 32'd0);
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                me = exp_q.pop_front();
                chk($sformatf("edge_no@%0d", me.cyc),  cyc, me.cyc);
                chk($sformatf("tick@%0d", me.cyc),     32'(tick),    32'(me.tk));
                chk($sformatf("div_clk@%0d", me.cyc),  32'(div_clk), 32'(me.dc));
                chk($sformatf("pending@%0d", me.cyc),  32'(pending), 32'(me.pd));
            end
            if (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
                mr = rsp_q.pop_front();
                chk($sformatf("rsp_no@%0d", mr.cyc), cyc, mr.cyc);
                chk($sformatf("ack_err@%0d", mr.cyc), 32'({cfg.cfg_ack, cfg.cfg_err}), 32'(mr.ae));
            end else if (cfg.cfg_ack || cfg.cfg_err) begin
                chk($sformatf("rsp_unexpected@%0d", cyc), 32'({cfg.cfg_ack, cfg.cfg_err}), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cfg.cfg_we   = 1'b0;
        cfg.cfg_ch   = '0;
        cfg.cfg_div  = '0;
        cfg3.cfg_we  = 1'b0;
        cfg3.cfg_ch  = '0;
        cfg3.cfg_div = '0;
        model_reset();

        repeat (3) @(posedge clock);
        #1;
        chk_zero("reset");
        reset = 1'b1;

        // Defaults: ratio 2 everywhere, first tick on edge 2.
        repeat (2) step();

        // Three-channel bank: channel code 3 is out of range, channel 2 is fine.
        cfg3.cfg_we  = 1'b1;
        cfg3.cfg_ch  = 2'd3;
        cfg3.cfg_div = 8'd5;
        step();
        chk("dut3_bad_ch_rsp", 32'({cfg3.cfg_ack, cfg3.cfg_err}), 32'b01);
        chk("dut3_bad_ch_pend", 32'(pending3), 32'd0);
        cfg3.cfg_ch  = 2'd2;
        cfg3.cfg_div = 8'd3;
        step();
        chk("dut3_ok_rsp", 32'({cfg3.cfg_ack, cfg3.cfg_err}), 32'b10);
        chk("dut3_ok_pend", 32'(pending3), 32'b100);
        cfg3.cfg_we = 1'b0;
        repeat (4) step();

        // ch1 := 5 at edge 9, applied at the wrap on edge 10; ratio 1 on ch0 rejected.
        wr(1, 5, 1'b1);
        pexp[1] = 1'b1;
        step();
        wr(0, 1, 1'b0);
        pexp[1] = 1'b0;
        anc[1]  = 10;
        rat[1]  = 5;
        step();
        step();

        // ch2 write lands on its wrap edge (12) and waits for edge 14.
        wr(2, 3, 1'b1);
        pexp[2] = 1'b1;
        step();
        wr(3, 4, 1'b1);
        pexp[3] = 1'b1;
        step();
        pexp[3:2] = 2'b00;
        anc[2] = 14;
        rat[2] = 3;
        anc[3] = 14;
        rat[3] = 4;
        step();
        repeat (5) step();

        // ch1 := 7 on its wrap edge 20, then align at 21 applies it along with a fresh ch0 := 6.
        wr(1, 7, 1'b1);
        pexp[1] = 1'b1;
        step();
        wr(0, 6, 1'b1);
        align = 1'b1;
        for (int i = 0; i < N; i++) anc[i] = 21;
        rat[0] = 6;
        rat[1] = 7;
        pexp   = '0;
        step();
        repeat (24) step();

        // Pending write on ch1, then a one-cycle reset clears everything.
        wr(1, 3, 1'b1);
        pexp[1] = 1'b1;
        step();
        step();
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk_zero("midreset");
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();

        repeat (8) step();
        // Largest ratio on ch3.
        wr(3, 255, 1'b1);
        pexp[3] = 1'b1;
        step();
        pexp[3] = 1'b0;
        anc[3]  = 10;
        rat[3]  = 255;
        step();
        repeat (520) step();

`ifdef CLKDIV_GATE_EN
        // ch0 gated for 10 edges with a pending ratio 4; first tick on the 4th edge after re-enable.
        wr(0, 4, 1'b1);
        ch_en[0] = 1'b0;
        dis[0]   = 1'b1;
        pexp[0]  = 1'b1;
        step();
        repeat (9) step();
        ch_en[0] = 1'b1;
        dis[0]   = 1'b0;
        pexp[0]  = 1'b0;
        anc[0]   = cyc_s;
        rat[0]   = 4;
        step();
        repeat (12) step();
`endif

        @(negedge clock);
        #1;
        chk("exp_queue_left", exp_q.size(), 0);
        chk("rsp_queue_left", rsp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
